// File: rtl/decoder_pkg.sv
// Shared constants for the one-hot decoder path: code widths and the
// state encoding of the hold/gap sequencer.
package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

endpackage

// File: rtl/decoder38.sv
// Purely combinational 3-to-8 one-hot decode.
import decoder_pkg::*;

module decoder38 (
  input  logic [CODE_W-1:0]   code,
  output logic [ONEHOT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/decoder38_hold.sv
// Registered 3-to-8 decoder with valid/ready input and a programmable
// hold time, followed by an optional all-zero gap, per decoded code.
import decoder_pkg::*;

module decoder38_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CODE_W-1:0]   din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [ONEHOT_W-1:0] dout,
  output logic                dout_valid,
  output logic                busy
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [ONEHOT_W-1:0] dout_n;
  logic                dout_valid_n;
  logic [ONEHOT_W-1:0] decoded;
  logic                accept;

  decoder38 u_decoder38 (
    .code   (din),
    .onehot (decoded)
  );

  assign accept = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
    end
  end

  // With GAP_CYCLES == 0 the last hold cycle doubles as an accept slot,
  // which is what allows back-to-back codes without an idle cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    dout_n       = dout;
    dout_valid_n = dout_valid;
    if (!en) begin
      state_n      = S_IDLE;
      cnt_n        = '0;
      dout_n       = '0;
      dout_valid_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_n      = S_HOLD;
            cnt_n        = HOLD_LOAD;
            dout_n       = decoded;
            dout_valid_n = 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_ONE;
          end else if (GAP_CYCLES > 0) begin
            state_n      = S_GAP;
            cnt_n        = GAP_LOAD;
            dout_n       = '0;
            dout_valid_n = 1'b0;
          end else if (accept) begin
            cnt_n        = HOLD_LOAD;
            dout_n       = decoded;
            dout_valid_n = 1'b1;
          end else begin
            state_n      = S_IDLE;
            cnt_n        = '0;
            dout_n       = '0;
            dout_valid_n = 1'b0;
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_ONE;
          end else begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n      = S_IDLE;
          cnt_n        = '0;
          dout_n       = '0;
          dout_valid_n = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    din_ready = 1'b0;
    if (en) begin
      case (state)
        S_IDLE:  din_ready = 1'b1;
        S_HOLD:  din_ready = (GAP_CYCLES == 0) && (cnt == '0);
        default: din_ready = 1'b0;
      endcase
    end
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_decoder38_hold.sv
// Directed bench for decoder38_hold: default (HOLD 4, GAP 1) instance
// plus a full-throughput (HOLD 1, GAP 0) instance.
module tb_decoder38_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] dina, dinb;
  logic       vala, valb;
  logic       rdya, rdyb;
  logic [7:0] douta, doutb;
  logic       dva, dvb;
  logic       busya, busyb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decoder38_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(dina), .din_valid(vala),
    .din_ready(rdya), .dout(douta), .dout_valid(dva), .busy(busya)
  );

  decoder38_hold #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(dinb), .din_valid(valb),
    .din_ready(rdyb), .dout(doutb), .dout_valid(dvb), .busy(busyb)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] code, input logic valid);
    dina = code;
    vala = valid;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the whole A-side output bundle at once.
  task automatic checkA(input string tag, input logic [7:0] d, input logic v,
                        input logic b, input logic r);
    checkOutput({tag, ".dout"}, douta, d);
    checkOutput({tag, ".dout_valid"}, {7'd0, dva}, {7'd0, v});
    checkOutput({tag, ".busy"}, {7'd0, busya}, {7'd0, b});
    checkOutput({tag, ".din_ready"}, {7'd0, rdya}, {7'd0, r});
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    applyStimulus(3'd0, 1'b0);
    dinb = 3'd0;
    valb = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkA("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_b.dout", doutb, 8'h00);
    checkOutput("reset_b.ready", {7'd0, rdyb}, 8'h01);

    // Single decode of 5: four cycles of 0x20, one gap cycle, then ready.
    applyStimulus(3'd5, 1'b1);
    tick();
    applyStimulus(3'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkA($sformatf("single.hold%0d", i), 8'h20, 1'b1, 1'b1, 1'b0);
      if (i < 3) tick();
    end
    tick();
    checkA("single.gap", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    checkA("single.idle", 8'h00, 1'b0, 1'b0, 1'b1);

    // Sweep 0..7 with valid held high; din moves to the next code right
    // after each accept, so an early consume would corrupt dout.
    applyStimulus(3'd0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("sweep%0d.ready", c), {7'd0, rdya}, 8'h01);
      tick();
      applyStimulus(3'(c + 1), 1'b1);
      for (int h = 0; h < 4; h++) begin
        checkA($sformatf("sweep%0d.hold%0d", c, h), 8'h01 << c, 1'b1, 1'b1, 1'b0);
        tick();
      end
      checkA($sformatf("sweep%0d.gap", c), 8'h00, 1'b0, 1'b1, 1'b0);
      if (c == 7) applyStimulus(3'd0, 1'b0);
      tick();
    end
    checkA("sweep.idle", 8'h00, 1'b0, 1'b0, 1'b1);

    // Back-to-back full throughput on the HOLD 1 / GAP 0 instance.
    dinb = 3'd3; valb = 1'b1;
    tick();
    checkOutput("b2b.first", doutb, 8'h08);
    checkOutput("b2b.ready", {7'd0, rdyb}, 8'h01);
    dinb = 3'd7;
    tick();
    checkOutput("b2b.second", doutb, 8'h80);
    dinb = 3'd0;
    tick();
    checkOutput("b2b.third", doutb, 8'h01);
    checkOutput("b2b.valid", {7'd0, dvb}, 8'h01);
    valb = 1'b0;
    tick();
    checkOutput("b2b.drain", doutb, 8'h00);
    checkOutput("b2b.busy", {7'd0, busyb}, 8'h00);

    // Abort: drop en in the second hold cycle of code 6.
    applyStimulus(3'd6, 1'b1);
    tick();
    applyStimulus(3'd6, 1'b0);
    checkA("abort.hold1", 8'h40, 1'b1, 1'b1, 1'b0);
    tick();
    checkA("abort.hold2", 8'h40, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    #1;
    checkOutput("abort.ready_drop", {7'd0, rdya}, 8'h00);
    tick();
    checkA("abort.cleared", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd1, 1'b1);
    tick();
    checkA("abort.disabled", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd1, 1'b0);
    en = 1'b1;
    #1;
    checkOutput("abort.ready_back", {7'd0, rdya}, 8'h01);

    // Reset during HOLD aborts the hold at once.
    applyStimulus(3'd3, 1'b1);
    tick();
    applyStimulus(3'd3, 1'b0);
    checkA("rsthold.hold", 8'h08, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    checkA("rsthold.after", 8'h00, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // Reset during GAP, then a new code accepted right after release.
    applyStimulus(3'd2, 1'b1);
    tick();
    applyStimulus(3'd2, 1'b0);
    for (int h = 0; h < 4; h++) tick();
    checkA("rstgap.gap", 8'h00, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(3'd3, 1'b1);
    tick();
    checkOutput("rstgap.busy", {7'd0, busya}, 8'h00);
    checkOutput("rstgap.dout", douta, 8'h00);
    rst = 1'b0;
    applyStimulus(3'd4, 1'b1);
    tick();
    applyStimulus(3'd4, 1'b0);
    checkA("rstgap.accept", 8'h10, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder38_hold.md
# decoder38_hold

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It sits on the consumer side of the 8-to-3 priority encoder path. It takes the encoder's 3-bit code, with the encoder's `flag` used as the valid signal, and drives a one-hot output such as an LED bank or a channel select. Each decoded output is held stable for a fixed number of cycles, optionally followed by an idle gap, before the next code is accepted.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles each one-hot output stays asserted; legal range ≥1.
- `GAP_CYCLES`, default 1: cycles of all-zero output after each hold; legal range ≥0.

Ports:
- `clk`  input  1  sole clock; all state on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `en`  input  1  block enable; low forces idle and clears output.
- `din`  input  3  binary code to decode.
- `din_valid`  input  1  `din` is valid; normally driven by the encoder `flag`.
- `din_ready`  output  1  block accepts `din` this cycle.
- `dout`  output  8  registered one-hot output; `dout[din]` is set.
- `dout_valid`  output  1  `dout` holds a decoded code.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, HOLD, GAP.
- Accept condition: `din_valid && din_ready` at a rising edge.
- IDLE:
  - `din_ready = en`.
  - On accept: `dout <= 8'b1 << din`, `dout_valid <= 1`, `cnt <= HOLD_CYCLES-1`, go to HOLD.
- HOLD:
  - `dout` and `dout_valid` are stable. `cnt` decrements each cycle.
  - At `cnt == 0`, if `GAP_CYCLES > 0`: `dout <= 0`, `dout_valid <= 0`, `cnt <= GAP_CYCLES-1`, go to GAP.
  - At `cnt == 0`, if `GAP_CYCLES == 0`: `din_ready = en` in this cycle.
    - On accept: load the new code and reload `cnt`; stay in HOLD. This is a back-to-back transfer.
    - With no accept: clear `dout` and `dout_valid`, go to IDLE.
- GAP:
  - `dout = 0`, `din_ready = 0`. `cnt` decrements.
  - At `cnt == 0`, go to IDLE.
- `din_ready` is combinational from state, `cnt` and `en`. It never depends on `din_valid`.
- `en` low in any state: the next edge gives state IDLE, `dout = 0`, `dout_valid = 0`, `cnt = 0`. While `en` is low, `din_ready = 0`.
- `rst` has priority over `en`. Reset values: state IDLE, `dout = 8'h00`, `dout_valid = 0`, `cnt = 0`. From these, `din_ready = en` and `busy = 0`.
- Reset asserted mid-HOLD or mid-GAP aborts immediately. No partial hold completes.
- Counter width: `$clog2(max(HOLD_CYCLES, GAP_CYCLES)+1)`, minimum 1 bit. There is no wrap-around. The counter is always reloaded before it reaches zero-minus-one.
- Legal `din` values are 0–7. Every 3-bit value is legal, so no error path exists.
- `dout` is always either exactly one-hot with `dout_valid = 1`, or all-zero with `dout_valid = 0`.

## Timing
- Latency: a code accepted at edge k appears on `dout` after edge k. It stays for exactly `HOLD_CYCLES` cycles, covering edges k+1 … k+HOLD_CYCLES.
- Minimum code-to-code period: `HOLD_CYCLES + GAP_CYCLES + 1` cycles when `GAP_CYCLES > 0`, and `HOLD_CYCLES` cycles when `GAP_CYCLES == 0`.
- `HOLD_CYCLES == 1` with `GAP_CYCLES == 0` gives full throughput: one code per cycle while `din_valid` stays high.
- `din_valid` held high during HOLD or GAP is not consumed. The upstream holds `din` until it sees `din_ready`.
- `en` deasserted and reasserted in the same cycle as an accept: `en` is sampled at that edge, so the accept happens only if `en` is high at that edge.

## Structure
- Shared package/header `decoder_pkg`:
  - state encoding localparams `S_IDLE`, `S_HOLD`, `S_GAP`, 2 bits;
  - `CODE_W = 3`;
  - `ONEHOT_W = 8`.
- Sub-module `decoder38`: purely combinational 3-to-8 one-hot decode. It is instantiated once, and its output is registered into `dout` on accept.
- Top level holds the FSM, the counter and the handshake logic.

## Test plan
- Reset and idle: hold `rst` for 2 cycles with `en = 1`, then release.
  - Required: `dout = 00`, `dout_valid = 0`, `busy = 0`, `din_ready = 1`.
- Single decode with defaults (HOLD 4, GAP 1): `din = 5` with valid for one cycle.
  - Required: `dout = 8'h20` for exactly 4 cycles, then `00` for 1 cycle, then `din_ready` returns.
- Full sweep: codes 0–7 streamed with `din_valid` held high.
  - Required: `dout` steps through 01, 02, 04 … 80, one code per 6 cycles.
  - Required: `din` is never consumed while `din_ready` is low.
- Back-to-back with `GAP_CYCLES = 0`, `HOLD_CYCLES = 1`: codes 3, 7, 0 on consecutive cycles.
  - Required: `dout` reads 08, 80, 01 on consecutive cycles.
- Abort: drop `en` during the 2nd HOLD cycle of code 6.
  - Required: `dout = 00` and state IDLE on the next edge.
  - Required: `din_ready = 0` until `en` returns.
- Reset mid-GAP: assert `rst` during GAP.
  - Required: next cycle `busy = 0`, `dout = 00`.
  - Required: a new code is accepted on the first cycle after reset is released.
